net_renderer: RTL and testbench

Parametrised, registered centre-net renderer for the Pong VGA pipeline. It sits alongside the paddle and ball renderers and feeds the pixel mux. It draws a dashed vertical net inside a fixed rectangle. The dash period is configurable, the dashes can scroll vertically at a frame-based rate, and the net colour flashes for a programmable number of frames after each score event.

---
 rtl/pong_pkg.sv | 6 +
 rtl/net_flash_fsm.sv | 64 ++++++
 rtl/net_renderer.sv | 83 ++++++++
 tb/tb_net_renderer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types for the Pong VGA pipeline renderers.
package pong_pkg;
  typedef logic [10:0] coord_t;
  typedef logic [11:0] rgb_t;
  typedef enum logic {NF_IDLE, NF_FLASH} net_flash_state_t;
endpackage

// File: rtl/net_flash_fsm.sv
// Net flash controller: counts down frames after a score and picks the net colour.
module net_flash_fsm
  import pong_pkg::*;
#(
  parameter rgb_t COLOR        = 12'hf0f,
  parameter rgb_t FLASH_COLOR  = 12'hfff,
  parameter int   FLASH_FRAMES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic score,
  output rgb_t color
);

  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

  net_flash_state_t state_reg, state_next;
  logic [7:0]       fl_cnt_reg, fl_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= NF_IDLE;
      fl_cnt_reg <= 8'd0;
    end else begin
      state_reg  <= state_next;
      fl_cnt_reg <= fl_cnt_next;
    end
  end

  // A score always reloads, even when it coincides with a frame_start.
  always_comb begin
    state_next  = state_reg;
    fl_cnt_next = fl_cnt_reg;
    case (state_reg)
      NF_IDLE: begin
        if (score) begin
          state_next  = NF_FLASH;
          fl_cnt_next = FLASH_LOAD;
        end
      end
      NF_FLASH: begin
        if (score) begin
          fl_cnt_next = FLASH_LOAD;
        end else if (frame_start) begin
          if (fl_cnt_reg == 8'd1) begin
            state_next  = NF_IDLE;
            fl_cnt_next = 8'd0;
          end else begin
            fl_cnt_next = fl_cnt_reg - 8'd1;
          end
        end
      end
      default: begin
        state_next  = NF_IDLE;
        fl_cnt_next = 8'd0;
      end
    endcase
  end

  // Bit 2 of the countdown toggles every four frames.
  assign color = (state_reg == NF_FLASH && fl_cnt_reg[2]) ? FLASH_COLOR : COLOR;

endmodule

// File: rtl/net_renderer.sv
// Dashed centre-net renderer with frame-rate scrolling and score flash; one-cycle registered output.
module net_renderer
  import pong_pkg::*;
#(
  parameter int   XLOC          = 100,
  parameter int   YLOC          = 100,
  parameter int   WIDTH         = 100,
  parameter int   HEIGHT        = 100,
  parameter int   DASH_LOG2     = 3,
  parameter rgb_t COLOR         = 12'hf0f,
  parameter rgb_t FLASH_COLOR   = 12'hfff,
  parameter int   FLASH_FRAMES  = 32,
  parameter int   SCROLL_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        active,
  input  logic        frame_start,
  input  logic        score,
  input  logic        net_en,
  output logic [11:0] rgb
);

  // 12-bit bounds so XLOC+WIDTH cannot overflow the 11-bit coordinate range.
  localparam logic [11:0] X_LO = 12'(XLOC);
  localparam logic [11:0] X_HI = 12'(XLOC + WIDTH);
  localparam logic [11:0] Y_LO = 12'(YLOC);
  localparam logic [11:0] Y_HI = 12'(YLOC + HEIGHT);
  localparam logic [7:0]  SCROLL_LAST = (SCROLL_FRAMES == 0) ? 8'd0 : 8'(SCROLL_FRAMES - 1);
  localparam logic        SCROLL_ON   = (SCROLL_FRAMES != 0);

  logic [7:0] fcnt_reg;
  coord_t     offset_reg;
  rgb_t       rgb_reg;
  rgb_t       net_color;
  coord_t     phase;
  logic       hit;
  logic       lit;

  net_flash_fsm #(
    .COLOR        (COLOR),
    .FLASH_COLOR  (FLASH_COLOR),
    .FLASH_FRAMES (FLASH_FRAMES)
  ) u_flash (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .score       (score),
    .color       (net_color)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_reg   <= 8'd0;
      offset_reg <= '0;
    end else if (frame_start) begin
      if (SCROLL_ON && fcnt_reg == SCROLL_LAST) begin
        fcnt_reg   <= 8'd0;
        offset_reg <= offset_reg + 11'd1;
      end else begin
        fcnt_reg <= fcnt_reg + 8'd1;
      end
    end
  end

  assign hit = ({1'b0, x} >= X_LO) && ({1'b0, x} <= X_HI) &&
               ({1'b0, y} >= Y_LO) && ({1'b0, y} <= Y_HI);
  assign phase = y + offset_reg;
  assign lit   = ~phase[DASH_LOG2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_reg <= '0;
    end else begin
      rgb_reg <= (active && net_en && hit && lit) ? net_color : 12'h000;
    end
  end

  assign rgb = rgb_reg;

endmodule

// File: tb/tb_net_renderer.sv
// Directed bench for net_renderer: scrolling instance plus a non-scrolling instance on shared inputs.
module tb_net_renderer;

  localparam logic [11:0] C = 12'hf0f;
  localparam logic [11:0] F = 12'hfff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] x = 11'd0;
  logic [10:0] y = 11'd0;
  logic        active = 1'b0;
  logic        frame_start = 1'b0;
  logic        score = 1'b0;
  logic        net_en = 1'b0;
  logic [11:0] rgb;
  logic [11:0] rgb_s;

  int checks = 0;
  int errors = 0;
  int m_fcnt = 0;
  int m_off  = 0;

  always #5 clk = ~clk;

  net_renderer dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .active(active),
    .frame_start(frame_start), .score(score), .net_en(net_en), .rgb(rgb)
  );

  net_renderer #(.SCROLL_FRAMES(0)) dut_s (
    .clk(clk), .rst(rst), .x(x), .y(y), .active(active),
    .frame_start(frame_start), .score(score), .net_en(net_en), .rgb(rgb_s)
  );

  function automatic logic [11:0] dash(input int yy, input int off, input logic [11:0] col);
    int ph;
    ph = (yy + off) % 2048;
    return (((ph >> 3) & 1) != 0) ? 12'h000 : col;
  endfunction

  function automatic logic [11:0] flash_col(input int cnt);
    return (cnt > 0 && ((cnt >> 2) & 1) != 0) ? F : C;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame_start cycle, optionally with a coincident score; tracks scroll model.
  task automatic frame(input logic sc);
    frame_start = 1'b1;
    score = sc;
    tick();
    frame_start = 1'b0;
    score = 1'b0;
    if (m_fcnt == 3) begin
      m_fcnt = 0;
      m_off = (m_off + 1) % 2048;
    end else begin
      m_fcnt++;
    end
  endtask

  task automatic test_reset();
    x = 11'd150; y = 11'd150; active = 1'b1; net_en = 1'b1; rst = 1'b1;
    tick(); tick();
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp %h", rgb, 12'h000); end
    checks++; if (rgb_s !== 12'h000) begin errors++; $display("FAIL reset_rgb_s got %h exp %h", rgb_s, 12'h000); end
    rst = 1'b0;
    tick();
    checks++; if (rgb !== C) begin errors++; $display("FAIL post_reset got %h exp %h", rgb, C); end
    checks++; if (rgb_s !== C) begin errors++; $display("FAIL post_reset_s got %h exp %h", rgb_s, C); end
    $display("reset: rgb=%h rgb_s=%h", rgb, rgb_s);
  endtask

  task automatic test_static_dash();
    logic [11:0] exp;
    x = 11'd150;
    for (int yy = 100; yy <= 131; yy++) begin
      y = 11'(yy);
      tick();
      exp = dash(yy, 0, C);
      checks++; if (rgb !== exp) begin errors++; $display("FAIL dash y=%0d got %h exp %h", yy, rgb, exp); end
      checks++; if (rgb_s !== exp) begin errors++; $display("FAIL dash_s y=%0d got %h exp %h", yy, rgb_s, exp); end
    end
    $display("static dash sweep y=100..131 done");
    x = 11'd200; y = 11'd100; tick();
    checks++; if (rgb !== C) begin errors++; $display("FAIL x_right_edge got %h exp %h", rgb, C); end
    x = 11'd201; tick();
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL x_past_right got %h exp %h", rgb, 12'h000); end
    x = 11'd100; tick();
    checks++; if (rgb !== C) begin errors++; $display("FAIL x_left_edge got %h exp %h", rgb, C); end
    x = 11'd99; tick();
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL x_before_left got %h exp %h", rgb, 12'h000); end
    x = 11'd150; y = 11'd99; tick();
    checks++; if (rgb_s !== 12'h000) begin errors++; $display("FAIL y_above_top got %h exp %h", rgb_s, 12'h000); end
    $display("edges: x=200 lit, x=201/99 dark, y=99 dark");
  endtask

  task automatic test_scroll();
    x = 11'd150; y = 11'd103;
    frame(1'b0); frame(1'b0); frame(1'b0);
    checks++; if (rgb !== C) begin errors++; $display("FAIL scroll_3 got %h exp %h", rgb, C); end
    frame(1'b0);
    // pixel presented during the 4th pulse still uses offset 0
    checks++; if (rgb !== C) begin errors++; $display("FAIL scroll_edge got %h exp %h", rgb, C); end
    tick();
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL scroll_off1 got %h exp %h", rgb, 12'h000); end
    checks++; if (rgb_s !== C) begin errors++; $display("FAIL noscroll got %h exp %h", rgb_s, C); end
    y = 11'd111; tick();
    checks++; if (rgb !== C) begin errors++; $display("FAIL scroll_y111 got %h exp %h", rgb, C); end
    checks++; if (rgb_s !== 12'h000) begin errors++; $display("FAIL noscroll_y111 got %h exp %h", rgb_s, 12'h000); end
    $display("scroll: offset 1 reached");
    for (int i = 0; i < 8184; i++) frame(1'b0);
    y = 11'd104; tick();
    checks++; if (rgb !== C) begin errors++; $display("FAIL off2047_y104 got %h exp %h", rgb, C); end
    for (int i = 0; i < 4; i++) frame(1'b0);
    tick();
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL wrap_y104 got %h exp %h", rgb, 12'h000); end
    y = 11'd103; tick();
    checks++; if (rgb !== C) begin errors++; $display("FAIL wrap_y103 got %h exp %h", rgb, C); end
    $display("scroll: offset wrapped to 0 after 8192 pulses");
  endtask

  task automatic test_flash();
    logic [11:0] col;
    x = 11'd150; y = 11'd100;
    score = 1'b1; tick(); score = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      frame(1'b0);
      tick();
      col = (k < 32) ? flash_col(32 - k) : C;
      checks++; if (rgb_s !== col) begin errors++; $display("FAIL flash_s k=%0d got %h exp %h", k, rgb_s, col); end
      checks++; if (rgb !== dash(100, m_off, col)) begin errors++; $display("FAIL flash k=%0d got %h exp %h", k, rgb, dash(100, m_off, col)); end
    end
    $display("flash: 32-frame episode finished, rgb_s=%h", rgb_s);
  endtask

  task automatic test_retrigger();
    logic [11:0] col;
    x = 11'd150; y = 11'd100;
    score = 1'b1; tick(); score = 1'b0;
    for (int i = 0; i < 10; i++) frame(1'b0);
    tick();
    checks++; if (rgb_s !== F) begin errors++; $display("FAIL flash_cnt22 got %h exp %h", rgb_s, F); end
    score = 1'b1; tick(); score = 1'b0; tick();
    checks++; if (rgb_s !== C) begin errors++; $display("FAIL retrig_cnt32 got %h exp %h", rgb_s, C); end
    for (int k = 1; k <= 32; k++) begin
      frame(1'b0);
      tick();
      col = (k < 32) ? flash_col(32 - k) : C;
      checks++; if (rgb_s !== col) begin errors++; $display("FAIL retrig k=%0d got %h exp %h", k, rgb_s, col); end
    end
    $display("retrigger: reload to 32 confirmed");
  endtask

  task automatic test_simultaneous();
    logic [11:0] col;
    x = 11'd150; y = 11'd100;
    score = 1'b1; tick(); score = 1'b0;
    for (int i = 0; i < 10; i++) frame(1'b0);
    frame(1'b1);
    tick();
    checks++; if (rgb_s !== C) begin errors++; $display("FAIL simul_cnt32 got %h exp %h", rgb_s, C); end
    for (int k = 1; k <= 32; k++) begin
      frame(1'b0);
      tick();
      col = (k < 32) ? flash_col(32 - k) : C;
      checks++; if (rgb_s !== col) begin errors++; $display("FAIL simul k=%0d got %h exp %h", k, rgb_s, col); end
    end
    $display("simultaneous score+frame_start: score wins");
  endtask

  task automatic test_gating();
    x = 11'd150; y = 11'd100;
    net_en = 1'b0; tick();
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL net_en_off got %h exp %h", rgb, 12'h000); end
    checks++; if (rgb_s !== 12'h000) begin errors++; $display("FAIL net_en_off_s got %h exp %h", rgb_s, 12'h000); end
    net_en = 1'b1; active = 1'b0; tick();
    checks++; if (rgb_s !== 12'h000) begin errors++; $display("FAIL active_off got %h exp %h", rgb_s, 12'h000); end
    active = 1'b1; tick();
    checks++; if (rgb_s !== C) begin errors++; $display("FAIL gate_restore got %h exp %h", rgb_s, C); end
    $display("gating: net_en/active blank the net");
  endtask

  task automatic test_reset_mid_flash();
    x = 11'd150; y = 11'd103;
    for (int i = 0; i < 40 && dash(103, m_off, C) != 12'h000; i++) frame(1'b0);
    score = 1'b1; tick(); score = 1'b0;
    frame(1'b0); frame(1'b0); tick();
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL pre_rst_dark got %h exp %h", rgb, 12'h000); end
    checks++; if (rgb_s !== F) begin errors++; $display("FAIL pre_rst_flash got %h exp %h", rgb_s, F); end
    rst = 1'b1; #1;
    checks++; if (rgb_s !== 12'h000) begin errors++; $display("FAIL async_rst got %h exp %h", rgb_s, 12'h000); end
    tick(); rst = 1'b0; m_off = 0; m_fcnt = 0;
    tick();
    checks++; if (rgb !== C) begin errors++; $display("FAIL rst_offset got %h exp %h", rgb, C); end
    checks++; if (rgb_s !== C) begin errors++; $display("FAIL rst_idle got %h exp %h", rgb_s, C); end
    $display("reset mid-flash: offset 0, IDLE colour");
  endtask

  initial begin
    test_reset();
    test_static_dash();
    test_scroll();
    test_flash();
    test_retrigger();
    test_simultaneous();
    test_gating();
    test_reset_mid_flash();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
